// File: rtl/snoop_resp_ctrl_md.sv
// -----------------------------------------------------------------------------
// snoop_resp_ctrl_md
//
// Registered snoop-response controller for one L1 cache.
//
// A bus snoop (read, read-exclusive or invalidate) is captured in IDLE. The hit
// way and its MESI state are resolved at capture time. The controller then
// steps through LOOKUP, an optional FLUSH of a Modified line (req/ack
// handshake), a one-cycle UPDATE strobe toward the tag/state array, and a
// one-cycle DONE pulse.
//
// Parameters
//   ASSOC      number of ways (default `ASSOC_LV1, 4 if not defined)
//   MESI_W     state width; I=00 S=01 E=10 M=11
//
// Optional feature macro
//   SNOOP_STATS_EN   builds saturating 16-bit hit and flush counters.
//                    When undefined, both counter ports are tied to 0.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   bus_rd, bus_rdx,
//   invalidate          snoop request levels (priority inv > rdx > rd)
//   access_blk_snoop    per-way tag match (ASSOC bits)
//   mesi_state_snoop    per-way state, way i at [i*MESI_W +: MESI_W]
//   flush_ack           bus accepted flush data
//   blk_hit_snoop       hit flag for the captured request (0 in IDLE)
//   shared_out          shared response, bus_rd hits only
//   flush_req           flush request, high for every FLUSH cycle
//   upd_en/upd_way/
//   upd_state           one-cycle state update to the tag array
//   snoop_busy          high outside IDLE
//   snoop_done          one-cycle completion pulse
//   multi_hit_err       sticky, more than one match bit
//   proto_err           sticky, invalidate hit an E or M line
//   snoop_hit_cnt,
//   snoop_flush_cnt     statistics counters
// -----------------------------------------------------------------------------
`ifndef ASSOC_LV1
`define ASSOC_LV1 4
`endif

module snoop_resp_ctrl_md #(
    parameter int ASSOC  = `ASSOC_LV1,
    parameter int MESI_W = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bus_rd,
    input  logic                      bus_rdx,
    input  logic                      invalidate,
    input  logic [ASSOC-1:0]          access_blk_snoop,
    input  logic [ASSOC*MESI_W-1:0]   mesi_state_snoop,
    input  logic                      flush_ack,
    output logic                      blk_hit_snoop,
    output logic                      shared_out,
    output logic                      flush_req,
    output logic                      upd_en,
    output logic [ASSOC-1:0]          upd_way,
    output logic [MESI_W-1:0]         upd_state,
    output logic                      snoop_busy,
    output logic                      snoop_done,
    output logic                      multi_hit_err,
    output logic                      proto_err,
    output logic [15:0]               snoop_hit_cnt,
    output logic [15:0]               snoop_flush_cnt
);

    localparam logic [MESI_W-1:0] ST_I = MESI_W'(0);
    localparam logic [MESI_W-1:0] ST_S = MESI_W'(1);
    localparam logic [MESI_W-1:0] ST_E = MESI_W'(2);
    localparam logic [MESI_W-1:0] ST_M = MESI_W'(3);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        FLUSH  = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state, state_nxt;

    // Resolved snoop outcome, captured in IDLE and held until the next capture.
    // These are data-path registers; every output use is gated by busy.
    logic              hit_r;
    logic              shared_r;
    logic              flush_r;
    logic              upd_r;
    logic              multi_r;
    logic              proto_r;
    logic [ASSOC-1:0]  way_r;
    logic [MESI_W-1:0] new_st_r;

    // Decode of the live inputs, only consumed in IDLE.
    logic              req_any;
    logic [ASSOC-1:0]  way_sel;
    logic [MESI_W-1:0] way_st;
    logic              dec_hit;
    logic              dec_multi;
    logic              dec_shared;
    logic              dec_flush;
    logic              dec_upd;
    logic              dec_proto;
    logic [MESI_W-1:0] dec_new_st;

    assign req_any = bus_rd | bus_rdx | invalidate;

    always_comb begin
        way_sel    = '0;
        way_st     = ST_I;
        dec_shared = 1'b0;
        dec_flush  = 1'b0;
        dec_upd    = 1'b0;
        dec_proto  = 1'b0;
        dec_new_st = ST_I;

        // Scan from the top so the lowest-index match wins.
        for (int i = ASSOC - 1; i >= 0; i--) begin
            if (access_blk_snoop[i]) begin
                way_sel    = '0;
                way_sel[i] = 1'b1;
                way_st     = mesi_state_snoop[i*MESI_W +: MESI_W];
            end
        end

        // Clearing the lowest set bit leaves something only on a multi-match.
        dec_multi = |(access_blk_snoop &
                      (access_blk_snoop - {{(ASSOC-1){1'b0}}, 1'b1}));
        dec_hit   = (|access_blk_snoop) && (way_st != ST_I);

        if (dec_hit) begin
            if (invalidate) begin
                dec_upd    = 1'b1;
                dec_new_st = ST_I;
                // A clean-shared invalidate is legal; E/M means another cache
                // believed it owned the line, which the protocol forbids.
                dec_proto  = (way_st == ST_E) || (way_st == ST_M);
            end else if (bus_rdx) begin
                dec_upd    = 1'b1;
                dec_new_st = ST_I;
                dec_flush  = (way_st == ST_M);
            end else begin
                dec_shared = 1'b1;
                dec_new_st = ST_S;
                dec_upd    = (way_st != ST_S);
                dec_flush  = (way_st == ST_M);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req_any) begin
            hit_r    <= dec_hit;
            shared_r <= dec_shared;
            flush_r  <= dec_flush;
            upd_r    <= dec_upd;
            multi_r  <= dec_multi;
            proto_r  <= dec_proto;
            way_r    <= way_sel;
            new_st_r <= dec_hit ? dec_new_st : way_st;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_any) state_nxt = LOOKUP;
            LOOKUP: begin
                if (!hit_r)       state_nxt = DONE;
                else if (flush_r) state_nxt = FLUSH;
                else if (upd_r)   state_nxt = UPDATE;
                else              state_nxt = DONE;
            end
            FLUSH:   if (flush_ack) state_nxt = UPDATE;
            UPDATE:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        snoop_busy    = (state != IDLE);
        flush_req     = (state == FLUSH);
        upd_en        = (state == UPDATE);
        snoop_done    = (state == DONE);
        blk_hit_snoop = snoop_busy & hit_r;
        shared_out    = snoop_busy & shared_r;
        upd_way       = snoop_busy ? (hit_r ? way_r : '0) : '0;
        upd_state     = snoop_busy ? new_st_r : ST_I;
    end

    // Sticky error flags, only cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            multi_hit_err <= 1'b0;
            proto_err     <= 1'b0;
        end else if (state == LOOKUP) begin
            if (multi_r) multi_hit_err <= 1'b1;
            if (proto_r) proto_err     <= 1'b1;
        end
    end

`ifdef SNOOP_STATS_EN
    logic [15:0] hit_cnt_r;
    logic [15:0] flush_cnt_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_r   <= 16'd0;
            flush_cnt_r <= 16'd0;
        end else begin
            if (state == LOOKUP && hit_r && hit_cnt_r != 16'hFFFF)
                hit_cnt_r <= hit_cnt_r + 16'd1;
            if (state == FLUSH && flush_ack && flush_cnt_r != 16'hFFFF)
                flush_cnt_r <= flush_cnt_r + 16'd1;
        end
    end

    assign snoop_hit_cnt   = hit_cnt_r;
    assign snoop_flush_cnt = flush_cnt_r;
`else
    assign snoop_hit_cnt   = 16'd0;
    assign snoop_flush_cnt = 16'd0;
`endif

endmodule
